// File: rtl/avr109_host.sv
// AVR109 programming initiator: streams word_count source words to a target bootloader
// over a byte UART (attach, P, A/B blocks, L, E), checking each 0x0D acknowledge.
module avr109_host #(
  parameter int BLOCK_WORDS    = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [7:0]  tx_data,
  output logic        tx_avail,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [4:0] {
    S_IDLE, S_ATTACH, S_CMD_P, S_BLK, S_A_CMD, S_A_HI, S_A_LO,
    S_B_CMD, S_B_HI, S_B_LO, S_B_F, S_FETCH, S_DATA_LO, S_DATA_HI,
    S_CMD_L, S_CMD_E, S_WAIT_CR, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_n, ret, ret_n;
  logic [15:0]   taddr, taddr_n, remain, remain_n, word, word_n, mem_addr_n;
  logic [7:0]    len, len_n, idx, idx_n, tx_data_n, snd_byte;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n, error_n, tx_avail_n, snd, can_send;
  logic [1:0]    err_code_n;

  // A send needs an idle transmitter and a gap cycle after the previous strobe.
  assign can_send = tx_ready && !tx_avail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ret      <= S_IDLE;
      taddr    <= '0;
      remain   <= '0;
      word     <= '0;
      len      <= '0;
      idx      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      mem_addr <= '0;
      tx_data  <= '0;
      tx_avail <= 1'b0;
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      taddr    <= taddr_n;
      remain   <= remain_n;
      word     <= word_n;
      len      <= len_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
      err_code <= err_code_n;
      mem_addr <= mem_addr_n;
      tx_data  <= tx_data_n;
      tx_avail <= tx_avail_n;
    end
  end

  always_comb begin
    state_n    = state;
    ret_n      = ret;
    taddr_n    = taddr;
    remain_n   = remain;
    word_n     = word;
    len_n      = len;
    idx_n      = idx;
    cnt_n      = '0;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = error;
    err_code_n = err_code;
    mem_addr_n = mem_addr;
    tx_data_n  = tx_data;
    tx_avail_n = 1'b0;
    snd        = 1'b0;
    snd_byte   = 8'h00;
    case (state)
      S_IDLE: if (start) begin
        taddr_n    = base_addr;
        remain_n   = word_count;
        mem_addr_n = '0;
        error_n    = 1'b0;
        err_code_n = 2'd0;
        busy_n     = 1'b1;
        idx_n      = '0;
        state_n    = S_ATTACH;
      end
      S_ATTACH: begin
        snd      = 1'b1;
        snd_byte = idx[0] ? 8'hAA : 8'h1B;
        if (can_send) begin
          if (idx == 8'd6) begin
            idx_n   = '0;
            state_n = S_CMD_P;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      S_CMD_P: begin
        snd = 1'b1; snd_byte = 8'h50;
        if (can_send) begin state_n = S_WAIT_CR; ret_n = S_BLK; end
      end
      S_BLK: begin
        if (remain == 16'd0) begin
          state_n = S_CMD_L;
        end else begin
          len_n   = (remain < 16'(BLOCK_WORDS)) ? remain[7:0] : 8'(BLOCK_WORDS);
          idx_n   = '0;
          state_n = S_A_CMD;
        end
      end
      S_A_CMD: begin
        snd = 1'b1; snd_byte = 8'h41;
        if (can_send) state_n = S_A_HI;
      end
      S_A_HI: begin
        snd = 1'b1; snd_byte = taddr[15:8];
        if (can_send) state_n = S_A_LO;
      end
      S_A_LO: begin
        snd = 1'b1; snd_byte = taddr[7:0];
        if (can_send) begin state_n = S_WAIT_CR; ret_n = S_B_CMD; end
      end
      S_B_CMD: begin
        snd = 1'b1; snd_byte = 8'h42;
        if (can_send) state_n = S_B_HI;
      end
      S_B_HI: begin
        snd = 1'b1; snd_byte = 8'h00;
        if (can_send) state_n = S_B_LO;
      end
      S_B_LO: begin
        snd = 1'b1; snd_byte = {len[6:0], 1'b0};
        if (can_send) state_n = S_B_F;
      end
      S_B_F: begin
        snd = 1'b1; snd_byte = 8'h46;
        if (can_send) state_n = S_FETCH;
      end
      S_FETCH: begin
        word_n  = mem_data;
        state_n = S_DATA_LO;
      end
      S_DATA_LO: begin
        snd = 1'b1; snd_byte = word[7:0];
        if (can_send) state_n = S_DATA_HI;
      end
      S_DATA_HI: begin
        snd = 1'b1; snd_byte = word[15:8];
        if (can_send) begin
          mem_addr_n = mem_addr + 16'd1;
          taddr_n    = taddr + 16'd1;
          if (idx == len - 8'd1) begin
            remain_n = remain - {8'h00, len};
            state_n  = S_WAIT_CR;
            ret_n    = S_BLK;
          end else begin
            idx_n   = idx + 8'd1;
            state_n = S_FETCH;
          end
        end
      end
      S_CMD_L: begin
        snd = 1'b1; snd_byte = 8'h4C;
        if (can_send) begin state_n = S_WAIT_CR; ret_n = S_CMD_E; end
      end
      S_CMD_E: begin
        snd = 1'b1; snd_byte = 8'h45;
        if (can_send) begin state_n = S_WAIT_CR; ret_n = S_DONE; end
      end
      S_WAIT_CR: begin
        if (rx_avail) begin
          if (rx_data == 8'h0D) begin
            state_n = ret;
            if (ret == S_DONE) begin done_n = 1'b1; busy_n = 1'b0; end
          end else begin
            state_n = S_ERROR; error_n = 1'b1; err_code_n = 2'd2; busy_n = 1'b0;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_ERROR; error_n = 1'b1; err_code_n = 2'd1; busy_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (snd && can_send) begin
      tx_avail_n = 1'b1;
      tx_data_n  = snd_byte;
    end
  end
endmodule

// File: tb/tb_avr109_host.sv
// Bench for avr109_host: a protocol-parsing target responder plus a stream model built from the session rules.
module tb_avr109_host;
  localparam int BW = 64;
  localparam int TO = 100;

  logic        clk, rst, start, busy, done, error, tx_avail, tx_ready, rx_avail;
  logic [15:0] base_addr, word_count, mem_addr, mem_data;
  logic [1:0]  err_code;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] mem [0:255];

  assign mem_data = mem[mem_addr[7:0]];

  avr109_host #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_data(tx_data), .tx_avail(tx_avail), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_avail(rx_avail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation and target-responder state (owned by the monitor process).
  logic [7:0] txq [$];
  int         txc [$];
  int         cyc = 0, done_cnt = 0, err_cyc = -1, viol = 0, seen_id = 0;
  bit         prev_avail = 0, prev_rdy = 0, prev_err = 0;
  int         need = 0, bpos = 0, pend = 0;
  bit         inb = 0;
  logic [7:0] cur = 8'h00, pend_byte = 8'h0D;
  // Owned by the main process: 0 normal, 1 withhold P reply, 2 bad A reply, 3 reset mid-data, 4 start on done.
  int         job_id = 0, rsp_mode = 0;

  task automatic parse(input logic [7:0] b);
    bit rep;
    rep = 1'b0;
    if (need > 0) begin
      if (inb) begin
        bpos++;
        if (bpos == 2) need += int'(b);
      end
      need--;
      rep = (need == 0);
    end else begin
      case (b)
        8'h50, 8'h4C, 8'h45: begin cur = b; rep = 1'b1; end
        8'h41: begin cur = b; need = 2; inb = 1'b0; end
        8'h42: begin cur = b; need = 3; inb = 1'b1; bpos = 0; end
        default: ;
      endcase
    end
    if (rep && !(rsp_mode == 1 && cur == 8'h50)) begin
      pend      = $urandom_range(1, 8);
      pend_byte = (rsp_mode == 2 && cur == 8'h41) ? 8'h3F : 8'h0D;
    end
  endtask

  initial begin
    tx_ready = 1'b0; rx_avail = 1'b0; rx_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (seen_id != job_id) begin
        seen_id = job_id;
        txq.delete(); txc.delete();
        done_cnt = 0; err_cyc = -1; viol = 0; need = 0; pend = 0;
      end
      rx_avail = 1'b0;
      if (done) done_cnt++;
      if (error && !prev_err && err_cyc < 0) err_cyc = cyc;
      prev_err = error;
      if (tx_avail) begin
        if (prev_avail || !prev_rdy) viol++;
        txq.push_back(tx_data);
        txc.push_back(cyc);
        parse(tx_data);
        // A stray byte during attach must be ignored by the host.
        if (txq.size() == 1) begin rx_avail = 1'b1; rx_data = 8'h55; end
      end
      prev_avail = tx_avail;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin rx_avail = 1'b1; rx_data = pend_byte; end
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      prev_rdy = tx_ready;
    end
  end

  logic [7:0] expq [$];

  task automatic build(input logic [15:0] base, input int n);
    int rem, off, len;
    logic [15:0] a;
    expq.delete();
    for (int i = 0; i < 7; i++) expq.push_back(i[0] ? 8'hAA : 8'h1B);
    expq.push_back(8'h50);
    a = base; off = 0; rem = n;
    while (rem > 0) begin
      len = (rem < BW) ? rem : BW;
      expq.push_back(8'h41); expq.push_back(a[15:8]); expq.push_back(a[7:0]);
      expq.push_back(8'h42); expq.push_back(8'h00); expq.push_back(8'(2 * len)); expq.push_back(8'h46);
      for (int i = 0; i < len; i++) begin
        expq.push_back(mem[off][7:0]);
        expq.push_back(mem[off][15:8]);
        off++;
        a = a + 16'd1;
      end
      rem -= len;
    end
    expq.push_back(8'h4C); expq.push_back(8'h45);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  task automatic run_job(input string tag, input logic [15:0] base, input int n, input int mode);
    int exp_len, n_cmp, e0;
    bit fin;
    build(base, n);
    rsp_mode = mode;
    job_id++;
    start = 1'b1; base_addr = base; word_count = 16'(n);
    @(negedge clk); #1;
    start = 1'b0; base_addr = 16'hDEAD; word_count = 16'd7;
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_err_clr"}, {error, err_code}, 0);
    // Second start mid-attach must be ignored.
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    fin = 1'b0;
    for (int b = 0; b < 20000 && !fin; b++) begin
      @(negedge clk); #1;
      if (mode == 3 && txq.size() == 18) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_avail"}, tx_avail, 0);
        check({tag, "_rst_txdata"}, tx_data, 0);
        check({tag, "_rst_memaddr"}, mem_addr, 0);
        check({tag, "_rst_flags"}, {done, error, err_code}, 0);
        @(negedge clk); #1 rst = 1'b0;
        fin = 1'b1;
      end else if (done || error) begin
        fin = 1'b1;
        if (mode == 4 && done) begin
          start = 1'b1; base_addr = 16'h0100; word_count = 16'd3;
          @(negedge clk); #1 start = 1'b0;
        end
      end
    end
    check({tag, "_finished"}, fin, 1);
    repeat (30) @(negedge clk);
    #1;
    exp_len = (mode == 1) ? 8 : (mode == 2) ? 11 : (mode == 3) ? 18 : expq.size();
    check({tag, "_len"}, txq.size(), exp_len);
    n_cmp = (txq.size() < exp_len) ? txq.size() : exp_len;
    for (int i = 0; i < n_cmp; i++) begin
      e0 = errors;
      check($sformatf("%s_byte%0d", tag, i), txq[i], expq[i]);
      if (errors != e0) break;
    end
    check({tag, "_done_cnt"}, done_cnt, (mode == 0 || mode == 4) ? 1 : 0);
    check({tag, "_error"}, error, (mode == 1 || mode == 2) ? 1 : 0);
    check({tag, "_err_code"}, err_code, (mode == 1) ? 1 : (mode == 2) ? 2 : 0);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_send_rule"}, viol, 0);
    if (mode == 1) begin
      check({tag, "_p_seen"}, txc.size() > 7, 1);
      if (txc.size() > 7) check({tag, "_to_cycles"}, err_cyc - txc[7], TO);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    fill_mem();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_err_code", err_code, 0);
    check("reset_tx_avail", tx_avail, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    fill_mem(); mem[0] = 16'hBEEF;
    run_job("single", 16'h1234, 1, 0);
    fill_mem();
    run_job("multi", 16'(($urandom_range(0, 255)) << 8), 130, 4);
    fill_mem();
    run_job("timeout", 16'h0040, 3, 1);
    fill_mem();
    run_job("badreply", 16'h1234, 2, 2);
    fill_mem();
    run_job("rerun", 16'h2000, 3, 0);
    run_job("empty", 16'h5555, 0, 0);
    fill_mem();
    run_job("wrap", 16'hFFFF, 2, 0);
    fill_mem();
    run_job("rstmid", 16'h0300, 5, 3);
    fill_mem();
    run_job("after_rst", 16'h0400, 4, 0);
    for (int k = 0; k < 4; k++) begin
      fill_mem();
      run_job($sformatf("rand%0d", k), 16'($urandom), $urandom_range(0, 140), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
